multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control unit for the 32-bit MIPS multicycle datapath (ALU, unified Memory, RegisterFile, MUX2/MUX4 selects, FlipFlopEn-based PC/IR).
- Moore FSM sequences fetch, decode, execute, memory and writeback. Emits every mux select and write enable.
- Includes an ALU decoder that maps op/funct to the 3-bit ALU control code.
- Sits beside the datapath. Inputs are instruction fields from the IR and the ALU zero flag.

Parameters:
- OP_W, 6, opcode field width.
- FUNCT_W, 6, funct field width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- pc_en  out  1  PC FlipFlopEn enable = pc_write | (branch & zero)
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  IR enable
- reg_dst  out  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = Data
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- pc_src  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- alu_control  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT

Behaviour:
- Clock and reset: single clock `clk`. `reset` is synchronous and active-high.
  - State register takes FETCH on the first rising edge with reset=1.
  - While reset=1, pc_en, mem_write, ir_write and reg_write are forced to 0. All other outputs follow the FETCH decode.
  - Reset mid-instruction abandons the instruction. No partial write occurs after the reset edge.
- Outputs: combinational from state (Moore). Exceptions are pc_en, which uses zero, and alu_control, which uses funct when alu_op=10.
- Default for any output not listed in a state: 0.
- States and asserted outputs:
  - FETCH: i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00, ir_write=1, pc_write=1. Next: DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next by op:
    - 100011 or 101011 -> MEMADR
    - 000000 -> RTYPEEX
    - 000100 -> BEQEX
    - 001000 -> ADDIEX
    - 000010 -> JEX
    - any other op -> FETCH (executes as a NOP, 2 cycles)
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD if op=100011, else MEMWR.
  - MEMRD: i_or_d=1. Next: MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEMWR: i_or_d=1, mem_write=1. Next: FETCH.
  - RTYPEEX: alu_src_a=1, alu_src_b=00, alu_op=10. Next: RTYPEWB.
  - RTYPEWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
  - BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1. Next: FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
  - JEX: pc_src=10, pc_write=1. Next: FETCH.
- Instruction latencies (cycles, FETCH to next FETCH): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- ALU decode:
  - alu_op 00 -> 010 (ADD)
  - alu_op 01 -> 110 (SUB)
  - alu_op 10 by funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other funct -> 010
- Unknown funct: the instruction still completes RTYPEWB (add semantics). It is not trapped.
- State encoding: 4-bit. Unused encodings transition to FETCH.

Optional Feature:
- Macro: MULTICYCLE_CONTROLLER_BNE_EN.
- Defined: op 000101 in DECODE -> BNEEX. BNEEX drives the same outputs as BEQEX, except pc_en = pc_write | (bne & ~zero). Next: FETCH. Latency 3 cycles.
- Undefined: op 000101 is an unknown opcode and returns DECODE -> FETCH as a NOP. BNEEX state and bne logic are absent.

Decomposition:
- Package `mc_pkg`:
  - state enum `mc_state_t`
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_BNE)
  - funct constants
  - ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT)
  - alu_src_b and pc_src encodings
- Sub-module `alu_decoder`: purely combinational, inputs alu_op[1:0] and funct, output alu_control. The FSM lives in the top module.

Test Plan:
- reset=1 for 2 cycles mid-RTYPEEX -> pc_en=mem_write=ir_write=reg_write=0 throughout; state=FETCH after the edge; first post-reset cycle has ir_write=1, pc_en=1, alu_src_b=01.
- lw (op=100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; MEMRD i_or_d=1; MEMWB reg_write=1, mem_to_reg=1, reg_dst=0. sw (op=101011) -> 4 cycles, mem_write=1 only in MEMWR.
- R-type op=000000 with funct 100010, then 101010 -> alu_control=110, then 111, in RTYPEEX; RTYPEWB reg_dst=1, reg_write=1; funct=111111 -> alu_control=010.
- beq with zero=1 -> BEQEX pc_en=1, pc_src=01; with zero=0 -> pc_en=0; 3 cycles each. j -> JEX pc_en=1, pc_src=10.
- addi (op=001000) -> ADDIEX alu_src_b=10, alu_control=010; ADDIWB reg_write=1, reg_dst=0, mem_to_reg=0.
- op=111111 -> FETCH, DECODE, FETCH; no write enable asserted in DECODE. With BNE_EN: op=000101, zero=0 -> BNEEX pc_en=1; zero=1 -> pc_en=0.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared types and encodings for the multicycle MIPS controller
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
    ,S_BNEEX  = 4'd12
`endif
  } mc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU_RESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALU_OUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP       = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps alu_op and funct to the 3-bit ALU control code
module alu_decoder
  import mc_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic [2:0]         alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALU_ADD;
      ALU_OP_SUB: alu_control = ALU_SUB;
      ALU_OP_FUNCT: begin
        // Unknown funct falls back to add rather than trapping.
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          default:   alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore control FSM for the MIPS multicycle datapath
// Optional bne support: define MULTICYCLE_CONTROLLER_BNE_EN.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               zero,
  output logic               pc_en,
  output logic               i_or_d,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [2:0]         alu_control
);

  mc_state_t state;
  mc_state_t dec_state;
  logic [1:0] alu_op;
  logic pc_write, branch, mem_write_raw, ir_write_raw, reg_write_raw;
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
  logic bne;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTYPEEX;
            OP_BEQ:       state <= S_BEQEX;
            OP_ADDI:      state <= S_ADDIEX;
            OP_J:         state <= S_JEX;
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
            OP_BNE:       state <= S_BNEEX;
`endif
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   state <= S_MEMWB;
        S_RTYPEEX: state <= S_RTYPEWB;
        S_ADDIEX:  state <= S_ADDIWB;
        default:   state <= S_FETCH;
      endcase
    end
  end

  // During reset the outputs show the FETCH decode with every write enable held low.
  always_comb begin
    dec_state     = reset ? S_FETCH : state;
    i_or_d        = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_src        = PCSRC_ALU_RESULT;
    alu_op        = ALU_OP_ADD;
    pc_write      = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
    bne           = 1'b0;
`endif
    case (dec_state)
      S_FETCH: begin
        alu_src_b    = SRCB_FOUR;
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: i_or_d = 1'b1;
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_MEMWR: begin
        i_or_d        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_RTYPEWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        pc_src    = PCSRC_ALU_OUT;
        branch    = 1'b1;
      end
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
      S_BNEEX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        pc_src    = PCSRC_ALU_OUT;
        bne       = 1'b1;
      end
`endif
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_JEX: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
    pc_en = ~reset & (pc_write | (branch & zero) | (bne & ~zero));
`else
    pc_en = ~reset & (pc_write | (branch & zero));
`endif
    mem_write = ~reset & mem_write_raw;
    ir_write  = ~reset & ir_write_raw;
    reg_write = ~reset & reg_write_raw;
  end

  alu_decoder #(
    .FUNCT_W(FUNCT_W)
  ) u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3, T_MEMWB = 4,
                 T_MEMWR = 5, T_RTEX = 6, T_RTWB = 7, T_BEQ = 8, T_ADDIEX = 9,
                 T_ADDIWB = 10, T_JEX = 11, T_BNE = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_control;

  int checks = 0;
  int errors = 0;

  logic [14:0] exp_q[$];
  string       tag_q[$];

  multicycle_controller dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .pc_en       (pc_en),
    .i_or_d      (i_or_d),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .alu_control (alu_control)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %04h (pc_en..alu_ctl) expected %04h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] observed();
    return {pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
            alu_src_a, alu_src_b, pc_src, alu_control};
  endfunction

  function automatic logic [2:0] funct_ctl(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Bit order: pc_en i_or_d mem_write ir_write reg_dst mem_to_reg reg_write alu_src_a asb[2] pcs[2] ctl[3]
  function automatic logic [14:0] exp_vec(input int st, input logic [5:0] f, input logic z);
    logic pe, iod, mw, irw, rd, m2r, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] ctl;
    {pe, iod, mw, irw, rd, m2r, rw, asa} = 8'b0;
    asb = 2'b00; pcs = 2'b00; ctl = 3'b010;
    case (st)
      T_FETCH:  begin pe = 1; irw = 1; asb = 2'b01; end
      T_DECODE: asb = 2'b11;
      T_MEMADR: begin asa = 1; asb = 2'b10; end
      T_MEMRD:  iod = 1;
      T_MEMWB:  begin m2r = 1; rw = 1; end
      T_MEMWR:  begin iod = 1; mw = 1; end
      T_RTEX:   begin asa = 1; ctl = funct_ctl(f); end
      T_RTWB:   begin rd = 1; rw = 1; end
      T_BEQ:    begin asa = 1; ctl = 3'b110; pcs = 2'b01; pe = z; end
      T_BNE:    begin asa = 1; ctl = 3'b110; pcs = 2'b01; pe = ~z; end
      T_ADDIEX: begin asa = 1; asb = 2'b10; end
      T_ADDIWB: rw = 1;
      T_JEX:    begin pcs = 2'b10; pe = 1; end
      default: ;
    endcase
    return {pe, iod, mw, irw, rd, m2r, rw, asa, asb, pcs, ctl};
  endfunction

  function automatic logic [14:0] reset_vec();
    logic [14:0] v;
    v = exp_vec(T_FETCH, 6'd0, 1'b0);
    v[14] = 1'b0; v[12] = 1'b0; v[11] = 1'b0; v[8] = 1'b0;
    return v;
  endfunction

  task automatic push(input string name, input int st, input logic [5:0] f, input logic z);
    exp_q.push_back(exp_vec(st, f, z));
    tag_q.push_back($sformatf("%s/s%0d", name, st));
  endtask

  // Expected state walk for one instruction, from FETCH up to the next FETCH.
  task automatic push_instr(input string name, input logic [5:0] o, input logic [5:0] f, input logic z);
    push(name, T_FETCH, f, z);
    push(name, T_DECODE, f, z);
    case (o)
      6'b100011: begin push(name, T_MEMADR, f, z); push(name, T_MEMRD, f, z); push(name, T_MEMWB, f, z); end
      6'b101011: begin push(name, T_MEMADR, f, z); push(name, T_MEMWR, f, z); end
      6'b000000: begin push(name, T_RTEX, f, z); push(name, T_RTWB, f, z); end
      6'b000100: push(name, T_BEQ, f, z);
      6'b001000: begin push(name, T_ADDIEX, f, z); push(name, T_ADDIWB, f, z); end
      6'b000010: push(name, T_JEX, f, z);
`ifdef MULTICYCLE_CONTROLLER_BNE_EN
      6'b000101: push(name, T_BNE, f, z);
`endif
      default: ;
    endcase
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: queue empty, got %04h expected none", observed());
      end else begin
        check(tag_q.pop_front(), observed(), exp_q.pop_front());
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f, input logic z);
    op = o; funct = f; zero = z;
    push_instr(name, o, f, z);
    run_cycles(exp_q.size());
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("reset%0d", i), observed(), reset_vec());
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_cycles(2);

    run_instr("lw",      6'b100011, 6'd0,      1'b0);
    run_instr("sw",      6'b101011, 6'd0,      1'b0);
    run_instr("sub",     6'b000000, 6'b100010, 1'b0);
    run_instr("slt",     6'b000000, 6'b101010, 1'b0);
    run_instr("and",     6'b000000, 6'b100100, 1'b1);
    run_instr("or",      6'b000000, 6'b100101, 1'b0);
    run_instr("add",     6'b000000, 6'b100000, 1'b0);
    run_instr("badfn",   6'b000000, 6'b111111, 1'b0);
    run_instr("beq_z1",  6'b000100, 6'd0,      1'b1);
    run_instr("beq_z0",  6'b000100, 6'd0,      1'b0);
    run_instr("j",       6'b000010, 6'd0,      1'b0);
    run_instr("addi",    6'b001000, 6'd0,      1'b0);
    run_instr("nop",     6'b111111, 6'd0,      1'b1);
    run_instr("bne_z0",  6'b000101, 6'd0,      1'b0);
    run_instr("bne_z1",  6'b000101, 6'd0,      1'b1);

    // Reset while in RTYPEEX abandons the instruction before RTYPEWB.
    op = 6'b000000; funct = 6'b100010; zero = 1'b0;
    push("rt_abort", T_FETCH, funct, zero);
    push("rt_abort", T_DECODE, funct, zero);
    run_cycles(2);
    reset_cycles(2);

    for (int k = 0; k < 6; k++) begin
      logic [5:0] f;
      f = 6'($urandom_range(0, 63));
      run_instr("rnd_rt", 6'b000000, f, 1'($urandom_range(0, 1)));
    end
    run_instr("final_lw", 6'b100011, 6'd0, 1'b0);

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
